// File: rtl/address_generator_if.sv
// Load-request and address bus between the accelerator controller and address_generator.
interface address_generator_if;
    logic       read;
    logic [7:0] Nk;
    logic [7:0] read_weight_base_addr;
    logic [7:0] read_neuro_base_addr;
    logic [7:0] write_neuro_base_addr;
    logic       finished;
    logic [7:0] neuro_read_addr;
    logic [7:0] weight_read_addr;
    logic [7:0] neuro_write_addr;

    modport master (
        output read, Nk, read_weight_base_addr, read_neuro_base_addr, write_neuro_base_addr,
        input  finished, neuro_read_addr, weight_read_addr, neuro_write_addr
    );

    modport slave (
        input  read, Nk, read_weight_base_addr, read_neuro_base_addr, write_neuro_base_addr,
        output finished, neuro_read_addr, weight_read_addr, neuro_write_addr
    );
endinterface

// File: rtl/address_generator.sv
// Streams neuron-RAM / weight-ROM read addresses and the result write address
// for the MAC core, with a one-cycle finished strobe per completed neuron.
module address_generator (
    input  logic             clk,
    input  logic             reset,
    address_generator_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0] state;
    logic [7:0] nk_q;
    logic [7:0] wbase;
    logic [7:0] nbase;
    logic [7:0] wnbase;
    logic [7:0] i_cnt;
    logic [7:0] k_cnt;
    logic [7:0] m_cnt;
    logic       fin_q;
    logic [7:0] nra_q;
    logic [7:0] wra_q;
    logic [7:0] nwa_q;

    logic [7:0] nk_last;
    logic       wrap;
    logic [7:0] i_nxt;
    logic [7:0] k_nxt;
    logic [7:0] m_nxt;

    // Nk of 0 behaves as 1, so the last input index is 0 in both cases.
    always_comb begin
        nk_last = (nk_q == 8'd0) ? 8'd0 : nk_q - 8'd1;
        wrap    = (i_cnt == nk_last);
        i_nxt   = wrap ? 8'd0 : i_cnt + 8'd1;
        k_nxt   = k_cnt + 8'd1;
        m_nxt   = fin_q ? m_cnt + 8'd1 : m_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            nk_q   <= 8'd0;
            wbase  <= 8'd0;
            nbase  <= 8'd0;
            wnbase <= 8'd0;
            i_cnt  <= 8'd0;
            k_cnt  <= 8'd0;
            m_cnt  <= 8'd0;
            fin_q  <= 1'b0;
            nra_q  <= 8'd0;
            wra_q  <= 8'd0;
            nwa_q  <= 8'd0;
        end else if (bus.read) begin
            state  <= LOAD;
            nk_q   <= bus.Nk;
            wbase  <= bus.read_weight_base_addr;
            nbase  <= bus.read_neuro_base_addr;
            wnbase <= bus.write_neuro_base_addr;
            i_cnt  <= 8'd0;
            k_cnt  <= 8'd0;
            m_cnt  <= 8'd0;
            fin_q  <= 1'b0;
            nra_q  <= bus.read_neuro_base_addr;
            wra_q  <= bus.read_weight_base_addr;
            nwa_q  <= bus.write_neuro_base_addr;
        end else if (state != IDLE) begin
            // The edge leaving LOAD already performs the first step, so C1 shows index 1.
            state  <= RUN;
            i_cnt  <= i_nxt;
            k_cnt  <= k_nxt;
            m_cnt  <= m_nxt;
            fin_q  <= wrap;
            nra_q  <= nbase + i_nxt;
            wra_q  <= wbase + k_nxt;
            nwa_q  <= wnbase + m_nxt;
        end
    end

    assign bus.finished         = fin_q;
    assign bus.neuro_read_addr  = nra_q;
    assign bus.weight_read_addr = wra_q;
    assign bus.neuro_write_addr = nwa_q;
endmodule

// File: tb/tb_address_generator.sv
// Self-checking bench for address_generator: directed scenarios plus randomized
// load/run/abort/reset sequences compared against a cycle-index reference model.
module tb_address_generator;
    logic clk = 1'b0;
    logic reset;

    address_generator_if bus ();

    address_generator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: outputs are a closed-form function of n, the cycle index since the last read edge.
    bit       running = 0;
    int       n = 0;
    int       lnk = 0;
    int       lwb = 0;
    int       lnb = 0;
    int       lwnb = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic tick();
        logic [7:0] e_nra, e_wra, e_nwa, e_fin;
        int nke;
        @(posedge clk);
        if (reset) begin
            running = 0;
        end else if (bus.read) begin
            running = 1;
            n = 0;
            lnk = int'(bus.Nk);
            lwb = int'(bus.read_weight_base_addr);
            lnb = int'(bus.read_neuro_base_addr);
            lwnb = int'(bus.write_neuro_base_addr);
        end else if (running) begin
            n++;
        end
        #1;
        if (!running) begin
            e_nra = 8'd0; e_wra = 8'd0; e_nwa = 8'd0; e_fin = 8'd0;
        end else begin
            nke   = (lnk == 0) ? 1 : lnk;
            e_nra = 8'((lnb + (n % nke)) % 256);
            e_wra = 8'((lwb + n) % 256);
            e_fin = (n > 0 && (n % nke) == 0) ? 8'd1 : 8'd0;
            e_nwa = (n == 0) ? 8'(lwnb) : 8'((lwnb + (n - 1) / nke) % 256);
        end
        check("neuro_read_addr",  bus.neuro_read_addr,  e_nra);
        check("weight_read_addr", bus.weight_read_addr, e_wra);
        check("neuro_write_addr", bus.neuro_write_addr, e_nwa);
        check("finished",         {7'd0, bus.finished}, e_fin);
    endtask

    task automatic load(input logic [7:0] nk, input logic [7:0] wb, input logic [7:0] nb,
                        input logic [7:0] wnb, input int len);
        bus.Nk = nk;
        bus.read_weight_base_addr = wb;
        bus.read_neuro_base_addr  = nb;
        bus.write_neuro_base_addr = wnb;
        bus.read = 1'b1;
        repeat (len) tick();
        bus.read = 1'b0;
    endtask

    // Runs with read low; optionally scribbles on Nk/bases, which must be ignored.
    task automatic run(input int cycles, input bit scramble);
        for (int c = 0; c < cycles; c++) begin
            if (scramble) begin
                bus.Nk = 8'($urandom);
                bus.read_weight_base_addr = 8'($urandom);
                bus.read_neuro_base_addr  = 8'($urandom);
                bus.write_neuro_base_addr = 8'($urandom);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.read = 1'b1;
        bus.Nk = 8'($urandom);
        bus.read_weight_base_addr = 8'($urandom);
        bus.read_neuro_base_addr  = 8'($urandom);
        bus.write_neuro_base_addr = 8'($urandom);

        // Reset with read also high, then idle with read low.
        repeat (2) tick();
        reset = 1'b0;
        bus.read = 1'b0;
        run(10, 1'b1);

        // Basic stream.
        load(8'd4, 8'd0, 8'd0, 8'd10, 2);
        run(12, 1'b0);

        // Offsets and address wrap.
        load(8'd3, 8'd250, 8'd254, 8'd255, 1);
        run(10, 1'b1);

        // Nk = 1 and Nk = 0.
        load(8'd1, 8'd7, 8'd33, 8'd254, 1);
        run(8, 1'b0);
        load(8'd0, 8'd7, 8'd33, 8'd254, 1);
        run(8, 1'b0);

        // Restart mid-stream at C6.
        load(8'd4, 8'd0, 8'd0, 8'd10, 1);
        run(6, 1'b0);
        load(8'd4, 8'd0, 8'd0, 8'd10, 1);
        run(10, 1'b0);

        // Reset and read together during a run.
        load(8'd5, 8'd100, 8'd50, 8'd20, 1);
        run(7, 1'b0);
        reset = 1'b1;
        bus.read = 1'b1;
        tick();
        reset = 1'b0;
        bus.read = 1'b0;
        run(6, 1'b1);

        // Randomized loads, runs, aborts and resets.
        for (int it = 0; it < 40; it++) begin
            logic [7:0] rnk;
            case ($urandom_range(0, 5))
                0:       rnk = 8'd0;
                1:       rnk = 8'd1;
                2:       rnk = 8'($urandom);
                default: rnk = 8'($urandom_range(2, 9));
            endcase
            load(rnk, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 3));
            run($urandom_range(0, 30), 1'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                bus.read = 1'($urandom);
                repeat ($urandom_range(1, 2)) tick();
                reset = 1'b0;
                bus.read = 1'b0;
                run($urandom_range(1, 5), 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
